// File: rtl/miner_pkg.sv
// Shared types and constants for the miner job sequencer: FSM states,
// miner control-word layout and the SHA3-256 padding bytes.
package miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_HALT,
    ST_DRAIN,
    ST_REPORT
  } seq_state_e;

  localparam int CTRL_W        = 19;
  localparam int CTRL_RUN      = 0;
  localparam int CTRL_TEST     = 1;
  localparam int CTRL_HALT     = 2;
  localparam int CTRL_PADL_LSB = 3;
  localparam int CTRL_PADF_LSB = 11;

  localparam logic [7:0] SHA3_PADF = 8'h06;
  localparam logic [7:0] SHA3_PADL = 8'h80;

  function automatic logic [CTRL_W-1:0] ctrl_word(input logic [7:0] padf,
                                                  input logic [7:0] padl,
                                                  input logic halt,
                                                  input logic test,
                                                  input logic run);
    return {padf, padl, halt, test, run};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter shared by the timed sequencer states. done pulses once,
// load_val+1 cycles after the cycle in which load is high.
module seq_cycle_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (done) begin
      armed <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = armed && !load && (cnt == '0);

endmodule

// File: rtl/miner_job_sequencer.sv
// Host-facing job sequencer for one sha3_256_miner: programs a job, runs it in
// halted/restarted chunks and returns found/exhausted/aborted. SETTLE_CYCLES >= 3, CHUNK_CYCLES >= 32.
module miner_job_sequencer
  import miner_pkg::*;
#(
  parameter int         CHUNK_CYCLES  = 4096,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         HALT_TIMEOUT  = 64,
  parameter logic [7:0] PADF          = SHA3_PADF,
  parameter logic [7:0] PADL          = SHA3_PADL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [255:0]      job_header,
  input  logic [255:0]      job_difficulty,
  input  logic [63:0]       job_start_nonce,
  input  logic [63:0]       job_end_nonce,
  input  logic              job_test,
  input  logic              abort,
  output logic [255:0]      m_header,
  output logic [255:0]      m_difficulty,
  output logic [63:0]       m_start_nonce,
  output logic [CTRL_W-1:0] m_control,
  input  logic [63:0]       m_solution,
  input  logic [6:0]        m_status,
  input  logic              m_irq,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_found,
  output logic              res_aborted,
  output logic [63:0]       res_nonce,
  output logic              busy
);

  localparam int CNT_W = $clog2(max3(CHUNK_CYCLES, HALT_TIMEOUT, SETTLE_CYCLES) + 1);

  // The timer load is registered, so it lands one cycle into the state: N-cycle states load N-2.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CHUNK_LOAD  = CNT_W'(CHUNK_CYCLES - 2);
  localparam logic [CNT_W-1:0] HALT_LOAD   = CNT_W'(HALT_TIMEOUT - 2);

  seq_state_e       state;
  logic [63:0]      end_nonce;
  logic [63:0]      next_nonce;
  logic             test_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             match;
  logic             unused_status;

  assign match         = m_irq && m_status[0];
  assign unused_status = ^m_status[6:1];

  seq_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      job_ready     <= 1'b1;
      busy          <= 1'b0;
      m_header      <= '0;
      m_difficulty  <= '0;
      m_start_nonce <= '0;
      m_control     <= '0;
      end_nonce     <= '0;
      next_nonce    <= '0;
      test_q        <= 1'b0;
      res_valid     <= 1'b0;
      res_found     <= 1'b0;
      res_aborted   <= 1'b0;
      res_nonce     <= '0;
      tmr_load      <= 1'b0;
      tmr_val       <= '0;
    end else begin
      tmr_load <= 1'b0;
      if (abort && (state == ST_SETTLE || state == ST_RUN || state == ST_HALT)) begin
        state     <= ST_DRAIN;
        m_control <= '0;
        res_nonce <= m_solution;
        tmr_load  <= 1'b1;
        tmr_val   <= SETTLE_LOAD;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (job_valid && job_ready) begin
              m_header      <= job_header;
              m_difficulty  <= job_difficulty;
              m_start_nonce <= job_start_nonce;
              next_nonce    <= job_start_nonce;
              end_nonce     <= job_end_nonce;
              test_q        <= job_test;
              res_found     <= 1'b0;
              res_aborted   <= 1'b0;
              job_ready     <= 1'b0;
              busy          <= 1'b1;
              tmr_load      <= 1'b1;
              tmr_val       <= SETTLE_LOAD;
              if (job_start_nonce > job_end_nonce) begin
                state     <= ST_REPORT;
                res_valid <= 1'b1;
                res_nonce <= job_start_nonce;
              end else begin
                state <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (tmr_done) begin
              state     <= ST_RUN;
              m_control <= ctrl_word(PADF, PADL, 1'b0, test_q, 1'b1);
              tmr_load  <= 1'b1;
              tmr_val   <= CHUNK_LOAD;
            end
          end
          ST_RUN: begin
            if (match) begin
              state     <= ST_REPORT;
              m_control <= '0;
              res_valid <= 1'b1;
              res_found <= 1'b1;
              res_nonce <= m_solution;
              tmr_load  <= 1'b1;
            end else if (tmr_done) begin
              state     <= ST_HALT;
              m_control <= ctrl_word(PADF, PADL, 1'b1, test_q, 1'b1);
              tmr_load  <= 1'b1;
              tmr_val   <= HALT_LOAD;
            end
          end
          ST_HALT: begin
            if (match) begin
              state     <= ST_REPORT;
              m_control <= '0;
              res_valid <= 1'b1;
              res_found <= 1'b1;
              res_nonce <= m_solution;
              tmr_load  <= 1'b1;
            end else if (m_irq) begin
              m_control <= '0;
              tmr_load  <= 1'b1;
              // Progress point at or past the end (or at 2^64-1) exhausts the job without wrapping.
              if (m_solution >= end_nonce || m_solution == '1) begin
                state     <= ST_REPORT;
                res_valid <= 1'b1;
                res_nonce <= m_solution;
              end else begin
                state         <= ST_SETTLE;
                next_nonce    <= m_solution + 64'd1;
                m_start_nonce <= m_solution + 64'd1;
                tmr_val       <= SETTLE_LOAD;
              end
            end else if (tmr_done) begin
              state       <= ST_REPORT;
              m_control   <= '0;
              res_valid   <= 1'b1;
              res_aborted <= 1'b1;
              res_nonce   <= next_nonce;
              tmr_load    <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (tmr_done) begin
              state       <= ST_REPORT;
              res_valid   <= 1'b1;
              res_aborted <= 1'b1;
              tmr_load    <= 1'b1;
            end
          end
          ST_REPORT: begin
            if (res_ready) begin
              state     <= ST_IDLE;
              res_valid <= 1'b0;
              job_ready <= 1'b1;
              busy      <= 1'b0;
              tmr_load  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miner_job_sequencer.sv
// Scoreboard bench for miner_job_sequencer with a behavioural miner model that
// matches, reports halt progress or stays silent depending on per-test settings.
module tb_miner_job_sequencer;
  import miner_pkg::*;

  localparam int SETTLE   = 4;
  localparam int HALT_LAT = 3;
  localparam logic [255:0] H1 = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] D1 = {64'h0000_0000_FFFF_0000, 192'h0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [255:0]      job_header = '0;
  logic [255:0]      job_difficulty = '0;
  logic [63:0]       job_start_nonce = '0;
  logic [63:0]       job_end_nonce = '0;
  logic              job_test = 1'b0;
  logic              abort = 1'b0;
  logic [255:0]      m_header;
  logic [255:0]      m_difficulty;
  logic [63:0]       m_start_nonce;
  logic [CTRL_W-1:0] m_control;
  logic [63:0]       m_solution = '0;
  logic [6:0]        m_status = '0;
  logic              m_irq = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic              res_found;
  logic              res_aborted;
  logic [63:0]       res_nonce;
  logic              busy;

  always #5 clk = ~clk;

  miner_job_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_difficulty  (job_difficulty),
    .job_start_nonce (job_start_nonce),
    .job_end_nonce   (job_end_nonce),
    .job_test        (job_test),
    .abort           (abort),
    .m_header        (m_header),
    .m_difficulty    (m_difficulty),
    .m_start_nonce   (m_start_nonce),
    .m_control       (m_control),
    .m_solution      (m_solution),
    .m_status        (m_status),
    .m_irq           (m_irq),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .res_aborted     (res_aborted),
    .res_nonce       (res_nonce),
    .busy            (busy)
  );

  typedef struct packed {
    logic        found;
    logic        aborted;
    logic [63:0] nonce;
  } result_t;

  result_t     exp_q[$];
  logic [63:0] rise_log[$];
  int total = 0, bad = 0, results_seen = 0, pushed = 0;
  int run_cycles = 0, zero_run = 0, halt_cnt = 0;

  // Model configuration, written only by the stimulus process.
  logic        match_en = 1'b0, halt_match_en = 1'b0, halt_resp_en = 1'b0;
  logic [63:0] match_nonce = '0, halt_match_nonce = '0, step = '0;
  logic [63:0] cur = '0;
  logic        prev_run = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic f, input logic a, input logic [63:0] n);
    result_t r;
    r.found   = f;
    r.aborted = a;
    r.nonce   = n;
    exp_q.push_back(r);
    pushed++;
  endtask

  task automatic cfg(input logic me, input logic [63:0] mn, input logic hme,
                     input logic [63:0] hmn, input logic hre, input logic [63:0] st);
    match_en = me; match_nonce = mn; halt_match_en = hme;
    halt_match_nonce = hmn; halt_resp_en = hre; step = st;
  endtask

  task automatic send_job(input logic [63:0] s, input logic [63:0] e, input logic t);
    int n = 0;
    while (!job_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("job_ready_before_send", 64'(job_ready), 64'd1);
    job_start_nonce = s;
    job_end_nonce   = e;
    job_test        = t;
    job_valid       = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget, input string name);
    int n = 0;
    while (results_seen < target && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    check(name, 64'(results_seen), 64'(target));
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!m_control[CTRL_RUN] && n < budget) begin
      @(negedge clk); n++;
    end
  endtask

  // Behavioural miner: irq stays raised until run drops, as the real core holds it.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_irq = 1'b0; m_status = '0; m_solution = '0;
      prev_run = 1'b0; zero_run = 0; halt_cnt = 0; cur = '0;
    end else if (!m_control[CTRL_RUN]) begin
      m_irq = 1'b0; m_status = '0;
      cur = m_start_nonce; halt_cnt = 0; zero_run++; prev_run = 1'b0;
    end else begin
      run_cycles++;
      if (!prev_run) begin
        rise_log.push_back(m_start_nonce);
        check("settle_before_run", 64'(zero_run >= SETTLE), 64'd1);
        zero_run = 0;
      end
      prev_run = 1'b1;
      if (!m_irq) begin
        if (m_control[CTRL_HALT]) begin
          halt_cnt++;
          if (halt_match_en && halt_cnt == 1) begin
            m_irq = 1'b1; m_status = 7'd1; m_solution = halt_match_nonce;
          end else if (halt_resp_en && halt_cnt == HALT_LAT) begin
            m_irq = 1'b1; m_status = 7'd0; m_solution = m_start_nonce + step;
          end
        end else if (match_en && cur == match_nonce) begin
          m_irq = 1'b1; m_status = 7'd1; m_solution = cur;
        end else begin
          cur = cur + 64'd1;
        end
      end
    end
  end

  // Result monitor: one pop per accepted result.
  always @(negedge clk) begin
    result_t e;
    if (rst_n && res_valid && res_ready) begin
      results_seen++;
      if (exp_q.size() == 0) begin
        check("extra_result", 64'(results_seen), 64'(pushed));
      end else begin
        e = exp_q.pop_front();
        check("res_found", 64'(res_found), 64'(e.found));
        check("res_aborted", 64'(res_aborted), 64'(e.aborted));
        check("res_nonce", res_nonce, e.nonce);
      end
    end
  end

  initial begin
    int n;
    int base;
    int halt_cycles;
    int run_base;
    logic [63:0] exp_starts [4];
    exp_starts[0] = 64'h0; exp_starts[1] = 64'h555;
    exp_starts[2] = 64'hAAA; exp_starts[3] = 64'hFFF;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_m_control", 64'(m_control), 64'd0);
    check("rst_m_start_nonce", m_start_nonce, 64'd0);
    check("rst_res_nonce", res_nonce, 64'd0);

    // Match at 0x105 inside the first chunk.
    cfg(1'b1, 64'h105, 1'b0, 64'h0, 1'b1, 64'h554);
    expect_result(1'b1, 1'b0, 64'h105);
    job_header = H1; job_difficulty = D1;
    send_job(64'h100, 64'hFFFF, 1'b1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_job_ready_low", 64'(job_ready), 64'd0);
    wait_run(200);
    check("t1_run_word", 64'(m_control), 64'h3403);
    check("t1_header", m_header[63:0], H1[63:0]);
    check("t1_difficulty", m_difficulty[255:192], D1[255:192]);
    check("t1_start_nonce", m_start_nonce, 64'h100);
    wait_results(1, 20000, "t1_result_count");
    repeat (50) @(posedge clk);
    check("t1_one_result", 64'(results_seen), 64'd1);

    // No match: four chunks with halt progress +0x554 each.
    cfg(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h554);
    base = rise_log.size();
    expect_result(1'b0, 1'b0, 64'h1553);
    send_job(64'h0, 64'h1000, 1'b0);
    wait_results(2, 30000, "t2_result_count");
    check("t2_restarts", 64'(rise_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_start_nonce_%0d", i), rise_log[base + i], exp_starts[i]);
    end

    // Genuine match visible on the first HALT cycle.
    cfg(1'b0, 64'h0, 1'b1, 64'hFFF, 1'b1, 64'h554);
    expect_result(1'b1, 1'b0, 64'hFFF);
    send_job(64'h0, 64'hFFFF, 1'b0);
    wait_results(3, 10000, "t3_result_count");

    // Abort coincident with a match irq.
    cfg(1'b1, 64'h264, 1'b0, 64'h0, 1'b1, 64'h554);
    expect_result(1'b0, 1'b1, 64'h264);
    send_job(64'h200, 64'hFFFF, 1'b0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!m_irq && n < 1000);
    check("t4_irq_seen", 64'(m_irq), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      if (i == 0) abort = 1'b0;
      check($sformatf("t4_drain_ctrl_%0d", i), 64'(m_control), 64'd0);
      check($sformatf("t4_drain_no_res_%0d", i), 64'(res_valid), 64'd0);
    end
    @(negedge clk);
    check("t4_report_after_drain", 64'(res_valid), 64'd1);
    wait_results(4, 100, "t4_result_count");

    // Miner never answers the halt: timeout after HALT_TIMEOUT cycles.
    cfg(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    res_ready = 1'b0;
    expect_result(1'b0, 1'b1, 64'h2000);
    send_job(64'h2000, 64'hFFFF, 1'b0);
    halt_cycles = 0; n = 0;
    while (!res_valid && n < 6000) begin
      @(negedge clk); n++;
      if (m_control[CTRL_HALT]) begin
        halt_cycles++;
        if (halt_cycles == 1) check("t5_halt_word", 64'(m_control), 64'h3405);
      end
    end
    check("t5_halt_cycles", 64'(halt_cycles), 64'd64);
    repeat (3) @(negedge clk);
    check("t5_hold_valid", 64'(res_valid), 64'd1);
    check("t5_hold_not_ready", 64'(job_ready), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_results(5, 10, "t5_result_count");
    check("t5_job_ready_back", 64'(job_ready), 64'd1);

    // start > end: immediate exhausted result, run never raised.
    cfg(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h554);
    run_base = run_cycles;
    expect_result(1'b0, 1'b0, 64'h10);
    send_job(64'h10, 64'h0F, 1'b0);
    wait_results(6, 50, "t6_result_count");
    repeat (10) @(posedge clk);
    check("t6_run_never", 64'(run_cycles - run_base), 64'd0);

    // Asynchronous reset mid-RUN.
    cfg(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h554);
    send_job(64'h3000, 64'hFFFF, 1'b0);
    wait_run(200);
    check("t7_running", 64'(m_control[CTRL_RUN]), 64'd1);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t7_ctrl_async", 64'(m_control), 64'd0);
    check("t7_job_ready", 64'(job_ready), 64'd1);
    check("t7_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("t7_no_result", 64'(results_seen), 64'd6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
